// File: rtl/data_ram.sv
// Single-port synchronous RAM that backs the fully associative cache.
// Each enabled rising edge performs one read or one write. Read data is
// registered. The first eight words are exported as combinational monitor taps.
// An asynchronous active-low clear zeroes the whole array and the read register.
//
// Ports:
//   clk        - clock; all non-reset activity happens on its rising edge
//   clr        - asynchronous active-low clear
//   enab       - chip enable; 0 means no read and no write
//   rw         - 0 = read, 1 = write (only meaningful when enab = 1)
//   Addr       - word address
//   data_in    - write data
//   mem0..mem7 - continuous view of words 0..7
//   data_out   - registered read data
module data_ram #(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned DEPTH   = 256
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               enab,
  input  logic               rw,
  input  logic [A_WIDTH-1:0] Addr,
  input  logic [D_WIDTH-1:0] data_in,
  output logic [D_WIDTH-1:0] mem0,
  output logic [D_WIDTH-1:0] mem1,
  output logic [D_WIDTH-1:0] mem2,
  output logic [D_WIDTH-1:0] mem3,
  output logic [D_WIDTH-1:0] mem4,
  output logic [D_WIDTH-1:0] mem5,
  output logic [D_WIDTH-1:0] mem6,
  output logic [D_WIDTH-1:0] mem7,
  output logic [D_WIDTH-1:0] data_out
);

  // Index width of the array. This is never wider than A_WIDTH because DEPTH <= 2^A_WIDTH.
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [A_WIDTH:0] DepthW = (A_WIDTH + 1)'(DEPTH);

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [D_WIDTH-1:0] data_out_q;
  logic [IdxW-1:0]    idx;
  logic               addr_ok;

  // Use one extra bit so the comparison still works when DEPTH == 2^A_WIDTH.
  assign addr_ok = ({1'b0, Addr} < DepthW);
  assign idx     = Addr[IdxW-1:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      data_out_q <= '0;
    end else if (enab) begin
      // An rw value that is neither 0 nor 1 falls into default: no update, and data_out holds.
      case (rw)
        1'b0: data_out_q <= addr_ok ? mem_q[idx] : '0;
        1'b1: begin
          if (addr_ok) begin
            mem_q[idx] <= data_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out = data_out_q;

  assign mem0 = mem_q[0];
  assign mem1 = mem_q[1];
  assign mem2 = mem_q[2];
  assign mem3 = mem_q[3];
  assign mem4 = mem_q[4];
  assign mem5 = mem_q[5];
  assign mem6 = mem_q[6];
  assign mem7 = mem_q[7];

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram. One instance uses the full depth and one uses DEPTH = 16.
// Both share the same stimulus. Read results are pushed to per-instance queues and popped
// after the rising edge that should produce them.
module tb_data_ram;

  logic       clk  = 1'b0;
  logic       clr  = 1'b1;
  logic       enab = 1'b0;
  logic       rw   = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] din  = 8'h00;

  logic [7:0] a_mon [8];
  logic [7:0] b_mon [8];
  logic [7:0] a_dout;
  logic [7:0] b_dout;

  // Reference models
  logic [7:0] ma [256];
  logic [7:0] mb [16];
  logic [7:0] da;
  logic [7:0] db;
  logic [7:0] qa [$];
  logic [7:0] qb [$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  data_ram u_dut (
    .clk      (clk),
    .clr      (clr),
    .enab     (enab),
    .rw       (rw),
    .Addr     (addr),
    .data_in  (din),
    .mem0     (a_mon[0]),
    .mem1     (a_mon[1]),
    .mem2     (a_mon[2]),
    .mem3     (a_mon[3]),
    .mem4     (a_mon[4]),
    .mem5     (a_mon[5]),
    .mem6     (a_mon[6]),
    .mem7     (a_mon[7]),
    .data_out (a_dout)
  );

  data_ram #(
    .D_WIDTH (8),
    .A_WIDTH (8),
    .DEPTH   (16)
  ) u_dut16 (
    .clk      (clk),
    .clr      (clr),
    .enab     (enab),
    .rw       (rw),
    .Addr     (addr),
    .data_in  (din),
    .mem0     (b_mon[0]),
    .mem1     (b_mon[1]),
    .mem2     (b_mon[2]),
    .mem3     (b_mon[3]),
    .mem4     (b_mon[4]),
    .mem5     (b_mon[5]),
    .mem6     (b_mon[6]),
    .mem7     (b_mon[7]),
    .data_out (b_dout)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s a.mem%0d", tag, i), a_mon[i], ma[i]);
      check($sformatf("%s b.mem%0d", tag, i), b_mon[i], mb[i]);
    end
    check($sformatf("%s a.data_out", tag), a_dout, da);
    check($sformatf("%s b.data_out", tag), b_dout, db);
  endtask

  task automatic clear_models();
    for (int i = 0; i < 256; i++) ma[i] = 8'h00;
    for (int i = 0; i < 16; i++) mb[i] = 8'h00;
    da = 8'h00;
    db = 8'h00;
    qa.delete();
    qb.delete();
  endtask

  // Drive one operation on the falling edge, then check just after the next rising edge.
  task automatic op(input string tag, input logic e, input logic r,
                    input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    enab = e;
    rw   = r;
    addr = a;
    din  = d;
    if (e === 1'b1 && r === 1'b0) begin
      qa.push_back(ma[a]);
      qb.push_back((a < 8'd16) ? mb[a[3:0]] : 8'h00);
    end else if (e === 1'b1 && r === 1'b1) begin
      ma[a] = d;
      if (a < 8'd16) mb[a[3:0]] = d;
    end
    @(posedge clk);
    #1;
    if (qa.size() > 0) da = qa.pop_front();
    if (qb.size() > 0) db = qb.pop_front();
    check_all(tag);
  endtask

  // Assert clr away from any clock edge and check that it acts without a clock.
  task automatic pulse_clr(input string tag);
    @(posedge clk);
    #2;
    clr = 1'b0;
    #1;
    clear_models();
    check_all(tag);
    @(negedge clk);
    #2;
    clr = 1'b1;
  endtask

  initial begin
    #12;
    // 1: first clear, applied between clock edges
    clr = 1'b0;
    #1;
    clear_models();
    check_all("t1_clr");
    @(negedge clk);
    #2;
    clr = 1'b1;
    op("t1_idle", 1'b0, 1'b0, 8'h00, 8'h00);

    // 2: writes do not disturb data_out; read back an upper address
    op("t2_wr3",    1'b1, 1'b1, 8'd3,   8'hA5);
    check("t2_mem3_lit", a_mon[3], 8'hA5);
    op("t2_wr200",  1'b1, 1'b1, 8'd200, 8'h3C);
    check("t2_dout_hold_lit", a_dout, 8'h00);
    op("t2_rd200",  1'b1, 1'b0, 8'd200, 8'h00);
    check("t2_rd200_lit", a_dout, 8'h3C);

    // 3: reads of word 3, then word 0
    op("t3_rd3", 1'b1, 1'b0, 8'd3, 8'h00);
    check("t3_rd3_lit", a_dout, 8'hA5);
    op("t3_rd0", 1'b1, 1'b0, 8'd0, 8'h00);
    check("t3_rd0_lit", a_dout, 8'h00);

    // 4: disabled write attempts are ignored
    for (int i = 0; i < 4; i++) op("t4_dis", 1'b0, 1'b1, 8'd3, 8'hFF);
    check("t4_mem3_lit", a_mon[3], 8'hA5);

    // rw unknown with enab=1: nothing changes
    op("tx_wr1", 1'b1, 1'b1, 8'd1, 8'h42);
    op("tx_rd1", 1'b1, 1'b0, 8'd1, 8'h00);
    op("tx_rwx", 1'b1, 1'bx, 8'd1, 8'h99);
    check("tx_mem1_lit", a_mon[1], 8'h42);

    // 5: read immediately after write, then an asynchronous clear mid-sequence
    op("t5_wr7", 1'b1, 1'b1, 8'd7, 8'h11);
    op("t5_rd7", 1'b1, 1'b0, 8'd7, 8'h00);
    check("t5_rd7_lit", a_dout, 8'h11);
    op("t5_idle", 1'b0, 1'b0, 8'd0, 8'h00);
    pulse_clr("t5_clr");
    op("t5_post", 1'b0, 1'b0, 8'd0, 8'h00);

    // 6: out-of-range access on the DEPTH=16 instance; in-range access on both
    op("t6_wr15", 1'b1, 1'b1, 8'd15, 8'h5A);
    op("t6_wr20", 1'b1, 1'b1, 8'd20, 8'h77);
    op("t6_rd20", 1'b1, 1'b0, 8'd20, 8'h00);
    check("t6_b_rd20_lit", b_dout, 8'h00);
    check("t6_a_rd20_lit", a_dout, 8'h77);
    op("t6_rd15", 1'b1, 1'b0, 8'd15, 8'h00);
    check("t6_b_rd15_lit", b_dout, 8'h5A);
    op("t6_wr2", 1'b1, 1'b1, 8'd2, 8'hC3);
    op("t6_idle", 1'b0, 1'b0, 8'd0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
